// File: rtl/npu_bus_master.sv
// npu_bus_master: host-side initiator for the NPU single-port memory-mapped
// slave. Turns write/read/poll commands into bus cycles, observes the slave's
// 1-cycle registered read latency, and inserts an idle gap after every
// control-register write so the slave's self-clearing pulses drop.
module npu_bus_master #(
    parameter int unsigned MAX_POLL   = 1024,
    parameter int unsigned POLL_CNT_W = 10,
    parameter logic [2:0]  CTRL_SEL   = 3'd4
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [2:0]  cmd_sel,
    input  logic [11:0] cmd_offset,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout,
    output logic        rsp_err,
    output logic        ena,
    output logic        wea,
    output logic [15:0] addra,
    output logic [31:0] dina,
    input  logic [31:0] douta
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [POLL_CNT_W-1:0] CNT_LAST = POLL_CNT_W'(MAX_POLL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_GAP,
        S_READ,
        S_CAPTURE,
        S_RSP
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [POLL_CNT_W-1:0] cnt_q, cnt_d;
    logic                  ena_q, ena_d;
    logic                  wea_q, wea_d;
    logic [15:0]           addra_q, addra_d;
    logic [31:0]           dina_q, dina_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  rsp_err_q, rsp_err_d;
    logic                  accept;

    assign cmd_ready   = (state_q == S_IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign ena         = ena_q;
    assign wea         = wea_q;
    assign addra       = addra_q;
    assign dina        = dina_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_err     = rsp_err_q;

    // State, latched command, bus outputs and response registers
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            op_q          <= OP_WRITE;
            cnt_q         <= '0;
            ena_q         <= 1'b0;
            wea_q         <= 1'b0;
            addra_q       <= '0;
            dina_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            ena_q         <= ena_d;
            wea_q         <= wea_d;
            addra_q       <= addra_d;
            dina_q        <= dina_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Next state; bus strobes are computed for the state being entered so
    // they come out of registers aligned with WRITE/READ
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        ena_d         = 1'b0;
        wea_d         = 1'b0;
        addra_d       = addra_q;
        dina_d        = dina_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        rsp_err_d     = rsp_err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = cmd_op;
                    addra_d = {1'b0, cmd_sel, cmd_offset};
                    unique case (cmd_op)
                        OP_WRITE: begin
                            state_d = S_WRITE;
                            ena_d   = 1'b1;
                            wea_d   = 1'b1;
                            dina_d  = cmd_wdata;
                        end
                        OP_READ, OP_POLL: begin
                            state_d = S_READ;
                            ena_d   = 1'b1;
                            cnt_d   = '0;
                        end
                        default: begin
                            state_d       = S_RSP;
                            rsp_valid_d   = 1'b1;
                            rsp_err_d     = 1'b1;
                            rsp_timeout_d = 1'b0;
                            rsp_data_d    = '0;
                        end
                    endcase
                end
            end
            S_WRITE: begin
                state_d = (addra_q[14:12] == CTRL_SEL) ? S_GAP : S_IDLE;
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_data_d = douta;
                rsp_err_d  = 1'b0;
                if (op_q != OP_POLL || douta[0]) begin
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_RSP;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else begin
                    state_d = S_READ;
                    ena_d   = 1'b1;
                    cnt_d   = cnt_q + POLL_CNT_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d       = S_IDLE;
                    rsp_valid_d   = 1'b0;
                    rsp_timeout_d = 1'b0;
                    rsp_err_d     = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
